// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state encodings, status constants and instruction field positions
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_EXEC  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic STATUS_HALT = 1'b0;
  localparam logic STATUS_RUN  = 1'b1;

  // Instruction byte layout shared with the control unit
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 6;
  localparam int RA_MSB  = 5;
  localparam int RA_LSB  = 3;
  localparam int RB_MSB  = 2;
  localparam int RB_LSB  = 0;

  function automatic logic [1:0] opcode_of(input logic [7:0] insn);
    return insn[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - program-memory and control-unit handshake bundle
interface fetch_sequencer_if #(
  parameter int PC_W = 8
) ();

  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [7:0]      mem_rdata;
  logic [7:0]      ir;
  logic            cu_start;
  logic            cu_done;

  modport master (
    output mem_req, mem_addr, ir, cu_start,
    input  mem_ack, mem_rdata, cu_done
  );

  modport slave (
    input  mem_req, mem_addr, ir, cu_start,
    output mem_ack, mem_rdata, cu_done
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// rtl/fetch_timeout_ctr.sv - clear/enable wait counter, expired on the TIMEOUT-th waiting cycle
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // count holds cycles already waited, so the current cycle is number count+1
  assign expired = en && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner: fetch, issue, wait for done, with run/step/halt and fetch timeout
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             pc_load,
  input  logic [PC_W-1:0]  pc_load_val,
  fetch_sequencer_if.master bus,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  state_t     state;
  logic       one_shot;
  logic       timeout;
  logic [7:0] ir_q;

  fetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_FETCH),
    .en      (state == ST_FETCH),
    .expired (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= '0;
      ir_q     <= '0;
      retired  <= '0;
      err      <= 1'b0;
      one_shot <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pc_load) begin
            pc <= pc_load_val;
          end else if (run == STATUS_RUN || step) begin
            state    <= ST_FETCH;
            one_shot <= step && (run == STATUS_HALT);
          end
        end
        ST_FETCH: begin
          // an ack arriving on the expiry cycle still wins
          if (bus.mem_ack) begin
            ir_q  <= bus.mem_rdata;
            state <= ST_ISSUE;
          end else if (timeout) begin
            err   <= 1'b1;
            state <= ST_ERROR;
          end
        end
        ST_ISSUE: state <= ST_EXEC;
        ST_EXEC: begin
          if (bus.cu_done) begin
            pc <= pc + 1'b1;
            if (retired != {CNT_W{1'b1}}) retired <= retired + 1'b1;
            state <= (run == STATUS_RUN && !one_shot) ? ST_FETCH : ST_IDLE;
          end
        end
        ST_ERROR: begin
          if (pc_load) pc <= pc_load_val;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req  = (state == ST_FETCH);
  assign bus.mem_addr = pc;
  assign bus.cu_start = (state == ST_ISSUE);
  assign bus.ir       = ir_q;
  assign busy         = (state != ST_IDLE) && (state != ST_ERROR);

endmodule
